// File: rtl/hpdl1414_scan_driver_pkg.sv
// Shared types and constants for the HPDL-1414 scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hpdl1414_scan_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SETUP  = 3'd3,
        ST_STROBE = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    localparam int NUM_DISPLAYS       = 4;
    localparam int DIGITS_PER_DISPLAY = 4;
    localparam int BUF_DEPTH          = 16;

    localparam logic [7:0] CHR_BLANK = 8'h20;
    localparam logic [7:0] CHR_MIN   = 8'h20;
    localparam logic [7:0] CHR_MAX   = 8'h5F;

    // The HPDL-1414 only has glyphs for 0x20..0x5F; anything else shows blank.
    function automatic logic [6:0] sanitize(input logic [7:0] b);
        if (b < CHR_MIN || b > CHR_MAX) begin
            return CHR_BLANK[6:0];
        end
        return b[6:0];
    endfunction

endpackage

// File: rtl/hpdl1414_scan_driver_tick_divider.sv
// Free-running divider: registered 1-cycle pulse every DIV cycles.
// Latency: first pulse DIV cycles after reset release.
// Backpressure: none, never stalls.
// Ports: clk, rst (async active-high), tick (pulse out).
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hpdl1414_scan_driver.sv
// Scans 16 buffer chars into four HPDL-1414 displays once per refresh tick; makes caret blink.
// Latency: frame = 16*(2+SETUP+WR+HOLD) cycles starting the cycle after the refresh tick.
// Backpressure: none; refresh ticks arriving while a frame is in progress are dropped.
// Ports: i_clk/i_rst; buffer read port o_read_enable/o_read_address/i_read_data;
//        o_caret_strobe to buffer; HPDL bus o_data/o_addr/o_wr_n; o_frame_done pulse.
module hpdl1414_scan_driver
    import hpdl1414_scan_driver_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int REFRESH_DIV  = 12_000,
    parameter int BLINK_DIV    = 3_000_000,
    parameter int SETUP_CYCLES = 2,
    parameter int WR_CYCLES    = 6,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_read_enable,
    output logic [3:0]              o_read_address,
    input  logic [7:0]              i_read_data,
    output logic                    o_caret_strobe,
    output logic [6:0]              o_data,
    output logic [1:0]              o_addr,
    output logic [NUM_DISPLAYS-1:0] o_wr_n,
    output logic                    o_frame_done
);

    localparam int PH_W = 16;

    // Elaboration-time sanity of the timing parameters.
    if (CLK_HZ < 1 || SETUP_CYCLES < 1 || WR_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("hpdl1414_scan_driver: invalid timing parameters");
    end

    logic            refresh_tick;
    logic            blink_tick;
    state_t          state, state_nxt;
    logic [3:0]      idx, idx_nxt;
    logic [PH_W-1:0] ph, ph_nxt;
    logic            done_nxt;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
        .clk  (i_clk),
        .rst  (i_rst),
        .tick (refresh_tick)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk  (i_clk),
        .rst  (i_rst),
        .tick (blink_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            ph    <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ph    <= ph_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ph_nxt    = ph;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (refresh_tick) begin
                    idx_nxt   = '0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_LATCH;
            ST_LATCH: begin
                ph_nxt    = '0;
                state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (ph == PH_W'(SETUP_CYCLES - 1)) begin
                    ph_nxt    = '0;
                    state_nxt = ST_STROBE;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            ST_STROBE: begin
                if (ph == PH_W'(WR_CYCLES - 1)) begin
                    ph_nxt    = '0;
                    state_nxt = ST_HOLD;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            ST_HOLD: begin
                if (ph == PH_W'(HOLD_CYCLES - 1)) begin
                    ph_nxt = '0;
                    if (idx == 4'(BUF_DEPTH - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe and read outputs are registered from the next state so the pins
    // are glitch-free and line up exactly with the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_read_enable  <= 1'b0;
            o_read_address <= '0;
            o_wr_n         <= '1;
            o_data         <= '0;
            o_addr         <= '0;
            o_frame_done   <= 1'b0;
            o_caret_strobe <= 1'b1;
        end else begin
            o_read_enable  <= (state_nxt == ST_FETCH);
            o_read_address <= idx_nxt;
            o_wr_n         <= (state_nxt == ST_STROBE) ? ~(4'b0001 << idx_nxt[3:2]) : 4'hF;
            o_frame_done   <= done_nxt;
            // Buffer read data is valid during LATCH; digit 3 is the leftmost.
            if (state == ST_LATCH) begin
                o_data <= sanitize(i_read_data);
                o_addr <= 2'(DIGITS_PER_DISPLAY - 1) - idx[1:0];
            end
            if (blink_tick) begin
                o_caret_strobe <= ~o_caret_strobe;
            end
        end
    end

endmodule
